// File: rtl/cic_pkg.sv
// Shared CIC definitions: stage count, default widths, FSM states and the
// output saturation helper used by both the interpolator and the decimator.
package cic_pkg;

    localparam int STAGES    = 5;
    localparam int DEF_IN_W  = 8;
    localparam int DEF_OUT_W = 8;
    localparam int DEF_ACC_W = 24;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } cic_state_e;

    // Clamp a sign-extended value to the signed range of a w-bit word.
    function automatic logic signed [63:0] sat_clip(input logic signed [63:0] x, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 32'sd1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 32'sd1));
        if (x > hi) begin
            sat_clip = hi;
        end else if (x < lo) begin
            sat_clip = lo;
        end else begin
            sat_clip = x;
        end
    endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// One comb section with differential delay 1: y = x - x[previous enabled sample].
module cic_comb_stage
    import cic_pkg::*;
#(
    parameter int ACC_W = DEF_ACC_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_en,
    input  logic signed [ACC_W-1:0] i_x,
    output logic signed [ACC_W-1:0] o_y
);

    logic signed [ACC_W-1:0] r_dly;

    // Delay register advances only when a low-rate sample enters the chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dly <= {ACC_W{1'b0}};
        end else if (i_en) begin
            r_dly <= i_x;
        end
    end

    assign o_y = i_x - r_dly;

endmodule

// File: rtl/cic_interpolator.sv
// Five-stage CIC interpolator: combs at the input rate, zero-stuffing by R,
// five integrators at the clock rate, then shift and saturate to OUT_W.
module cic_interpolator
    import cic_pkg::*;
#(
    parameter int IN_W  = DEF_IN_W,
    parameter int OUT_W = DEF_OUT_W,
    parameter int ACC_W = DEF_ACC_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [15:0]             interp_ratio,
    input  logic [4:0]              out_shift,
    input  logic signed [IN_W-1:0]  d_in,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic signed [OUT_W-1:0] d_out,
    output logic                    out_valid,
    output logic                    underrun
);

    cic_state_e              r_state;
    cic_state_e              w_state_nxt;
    logic [15:0]             r_ratio;
    logic [15:0]             r_phase;
    logic [2:0]              r_run_cnt;
    logic                    r_out_valid;
    logic                    r_underrun;
    logic signed [OUT_W-1:0] r_dout;
    logic signed [ACC_W-1:0] r_comb;
    logic signed [ACC_W-1:0] r_integ [STAGES];
    logic signed [ACC_W-1:0] w_stage [STAGES+1];
    logic signed [ACC_W-1:0] w_shifted;
    logic                    w_slot;
    logic                    w_ready;
    logic                    w_xfer;
    logic                    w_miss;
    logic                    w_comb_en;

    assign w_slot = (r_state == ST_RUN) && (r_phase == (r_ratio - 16'd1));

    // Readiness: always in IDLE, only on the last phase while running.
    always_comb begin
        w_ready = 1'b0;
        if (rst) begin
            w_ready = 1'b0;
        end else if (r_state == ST_IDLE) begin
            w_ready = 1'b1;
        end else begin
            w_ready = w_slot;
        end
    end

    assign w_xfer    = in_valid & w_ready;
    assign w_miss    = w_slot & ~in_valid & ~rst;
    assign w_comb_en = w_xfer | w_miss;
    assign w_stage[0] = w_xfer ? {{(ACC_W-IN_W){d_in[IN_W-1]}}, d_in} : {ACC_W{1'b0}};

    for (genvar g = 0; g < STAGES; g++) begin : g_comb
        cic_comb_stage #(.ACC_W(ACC_W)) u_comb (
            .clk  (clk),
            .rst  (rst),
            .i_en (w_comb_en),
            .i_x  (w_stage[g]),
            .o_y  (w_stage[g+1])
        );
    end

    // Next-state logic: RUN is only left through reset.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_xfer) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN:  w_state_nxt = ST_RUN;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Ratio is captured once on the first transfer; zero behaves as one.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ratio <= 16'd1;
        end else if ((r_state == ST_IDLE) && w_xfer) begin
            r_ratio <= (interp_ratio == 16'd0) ? 16'd1 : interp_ratio;
        end
    end

    // Phase counter wraps at R-1, aligned so phase 0 follows each input slot.
    always_ff @(posedge clk) begin
        if (rst || (r_state == ST_IDLE) || w_slot) begin
            r_phase <= 16'd0;
        end else begin
            r_phase <= r_phase + 16'd1;
        end
    end

    // out_valid rises once the pipeline has been filled for six RUN edges.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_run_cnt   <= 3'd0;
            r_out_valid <= 1'b0;
        end else if (r_state == ST_RUN) begin
            if (r_run_cnt != 3'd6) begin
                r_run_cnt <= r_run_cnt + 3'd1;
            end
            r_out_valid <= (r_run_cnt >= 3'd5);
        end
    end

    // Comb result is held for exactly one cycle, giving the zero-stuffed stream.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_comb <= {ACC_W{1'b0}};
        end else begin
            r_comb <= w_comb_en ? w_stage[STAGES] : {ACC_W{1'b0}};
        end
    end

    // Integrator cascade at the clock rate, modular arithmetic.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                r_integ[i] <= {ACC_W{1'b0}};
            end
        end else begin
            r_integ[0] <= r_integ[0] + r_comb;
            for (int i = 1; i < STAGES; i++) begin
                r_integ[i] <= r_integ[i] + r_integ[i-1];
            end
        end
    end

    assign w_shifted = r_integ[STAGES-1] >>> out_shift;

    // Output register and sticky underrun flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dout     <= {OUT_W{1'b0}};
            r_underrun <= 1'b0;
        end else begin
            r_dout <= OUT_W'(sat_clip({{(64-ACC_W){w_shifted[ACC_W-1]}}, w_shifted}, OUT_W));
            if (w_miss) begin
                r_underrun <= 1'b1;
            end
        end
    end

    assign in_ready  = w_ready;
    assign d_out     = r_dout;
    assign out_valid = r_out_valid;
    assign underrun  = r_underrun;

endmodule

// File: doc/cic_interpolator.md
CIC_INTERPOLATOR -- requirements
Module: cic_interpolator

Interface
REQ-001 SHALL have parameter IN_W, default 8, signed input sample width.
REQ-002 SHALL have parameter OUT_W, default 8, signed output sample width.
REQ-003 SHALL have parameter ACC_W, default 24, comb/integrator register width; supports ratio 1..16.
REQ-004 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port interp_ratio  input  16  interpolation ratio R, unsigned.
REQ-007 SHALL have port out_shift  input  5  arithmetic right shift applied before output saturation.
REQ-008 SHALL have port d_in  input  IN_W  signed low-rate sample.
REQ-009 SHALL have port in_valid  input  1  d_in holds a sample.
REQ-010 SHALL have port in_ready  output  1  block accepts d_in this cycle.
REQ-011 SHALL have port d_out  output  OUT_W  signed high-rate sample, one per clock.
REQ-012 SHALL have port out_valid  output  1  d_out is valid.
REQ-013 SHALL have port underrun  output  1  sticky flag: input slot missed while running.

Function
REQ-014 SHALL use 5 comb stages (differential delay 1) at input rate, zero-stuffing by R, then 5 integrator stages at clock rate.
REQ-015 SHALL implement a 2-state FSM: IDLE and RUN.
REQ-016 In IDLE, in_ready SHALL be 1 and out_valid 0; a transfer (in_valid & in_ready) SHALL latch R, set phase to 0 and enter RUN.
REQ-017 An R value of 0 SHALL be treated as 1; R SHALL be latched only on the IDLE->RUN transfer, and later interp_ratio changes SHALL be ignored until reset.
REQ-018 In RUN, phase SHALL count 0..R-1 and wrap; in_ready SHALL be 1 only when phase==R-1. For R=1, in_ready SHALL be 1 every cycle.
REQ-019 On a transfer, all comb delay registers SHALL update and the comb result SHALL be registered on the same edge.
REQ-020 On the cycle after a transfer, the registered comb result SHALL feed integrator 1; on all other cycles, integrator 1 SHALL add zero.
REQ-021 If in RUN at phase==R-1 with in_valid=0, a zero sample SHALL enter the combs, underrun SHALL set, and the FSM SHALL stay in RUN.
REQ-022 Comb and integrator arithmetic SHALL be ACC_W-bit two's-complement with modular wrap; d_in SHALL be sign-extended.
REQ-023 Each integrator output SHALL be registered; d_out SHALL register sat_OUT_W(integ5 >>> out_shift).
REQ-024 Saturation SHALL clamp to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
REQ-025 Latency: a sample transferred on edge t SHALL first affect d_out after edge t+6.
REQ-026 out_valid SHALL be 1 on every cycle after the FSM has been in RUN for 6 edges, and 0 otherwise.
REQ-027 out_shift SHALL take effect on the next d_out register update without disturbing internal state.
REQ-028 DC gain SHALL be R^4; a constant input x SHALL settle to x*R^4 >>> out_shift after saturation.

Reset
REQ-029 While rst=1: FSM=IDLE, phase=0, all comb/integrator registers=0, d_out=0, out_valid=0, in_ready=0, underrun=0.
REQ-030 Reset asserted mid-operation SHALL discard all in-flight samples on that edge.
REQ-031 After reset, the first clock SHALL present in_ready=1 in IDLE.

Structure
REQ-032 Package cic_pkg SHALL hold the STAGES=5 constant, default widths and the saturation function, shared with the decimator.
REQ-033 A single sub-module cic_comb_stage (enable, ACC_W delay register, subtract) SHALL be instantiated 5 times.

Verification
REQ-034 Impulse: R=1, shift=0, samples 1 then 0s -> d_out=1 exactly 6 edges after the transfer, 0 afterwards.
REQ-035 Impulse: R=2, shift=0, single sample 1 -> d_out sequence 1,5,10,10,5,1, then zeros.
REQ-036 Step: R=4, shift=8, constant d_in=10 -> d_out settles to 10; d_in=-128 settles to -128; in_ready pulses every 4 cycles.
REQ-037 Saturation: R=16, shift=0, d_in=127 constant -> d_out clamps at 127; d_in=-128 -> d_out clamps at -128.
REQ-038 Underrun: R=4, drop in_valid for one slot -> underrun=1 and stays 1; d_out continues as if a zero sample was sent.
REQ-039 Reset mid-run with R=8 -> next cycle d_out=0, out_valid=0, in_ready=1; change interp_ratio mid-run -> spacing of in_ready unchanged.
